// File: rtl/dense_weight_fetch_if.sv
// ROM read port plus weight stream for dense_weight_fetch.
// master = the fetch sequencer, slave = ROM/MAC side.
interface dense_weight_fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;

  modport master (
    output mem_en, mem_addr, w_data, w_valid, w_last,
    input  mem_rdata, w_ready
  );

  modport slave (
    input  mem_en, mem_addr, w_data, w_valid, w_last,
    output mem_rdata, w_ready
  );
endinterface

// File: rtl/dense_weight_fetch.sv
// Dense-layer weight ROM read sequencer with a 2-entry skid buffer feeding the MAC stream.
// Optional DENSE_FETCH_OFFSET_EN adds OFFSET to each weight as it is captured.
module dense_weight_fetch #(
  parameter int unsigned NUM_WEIGHTS = 507,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int          OFFSET      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  dense_weight_fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WEIGHTS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] issue_q, issue_d;
  logic              inflight_q, inflight_last_q;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [1:0]        buf_last_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              done_q;

  logic              push, pop, issue, issue_last, head_last;
  logic [2:0]        level;
  logic [DATA_W-1:0] cap_data;

  assign push       = inflight_q;
  assign pop        = (count_q != 2'd0) && bus.w_ready;
  assign head_last  = buf_last_q[rd_ptr_q];
  // Slots committed next cycle: entries held plus the read in flight, less a pop this cycle.
  assign level      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == StFetch) && (level < 3'd2);
  assign issue_last = issue && (issue_q == LastAddr);

`ifdef DENSE_FETCH_OFFSET_EN
  assign cap_data = bus.mem_rdata + DATA_W'(OFFSET);
`else
  assign cap_data = bus.mem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    case (state_q)
      StIdle: begin
        // done_q high means the previous run just ended; its start is dropped.
        if (start && !done_q) begin
          state_d = StFetch;
          issue_d = '0;
        end
      end
      StFetch: begin
        if (issue) begin
          if (issue_last) state_d = StFlush;
          else            issue_d = issue_q + 1'b1;
        end
      end
      StFlush: begin
        if (pop && head_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      issue_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      count_q         <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q      <= 2'b00;
    end else begin
      state_q         <= state_d;
      issue_q         <= issue_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      done_q          <= (state_q == StFlush) && pop && head_last;
      if (push) begin
        buf_data_q[wr_ptr_q] <= cap_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign bus.mem_en   = issue;
  assign bus.mem_addr = issue_q;
  assign bus.w_valid  = (count_q != 2'd0);
  assign bus.w_data   = buf_data_q[rd_ptr_q];
  assign bus.w_last   = head_last && (count_q != 2'd0);

endmodule

// File: tb/tb_dense_weight_fetch.sv
// Directed bench for dense_weight_fetch: a 507-weight instance and a 1-weight instance.
// Expected weights follow DENSE_FETCH_OFFSET_EN (OFFSET=-1 when defined).
module tb_dense_weight_fetch;

  localparam int N = 507;
`ifdef DENSE_FETCH_OFFSET_EN
  localparam logic [7:0] Off8 = 8'hFF;
`else
  localparam logic [7:0] Off8 = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start, busy, done;
  logic start1, busy1, done1;
  int   total = 0;
  int   bad = 0;
  int   beats, dones;

  always #5 clk = ~clk;

  dense_weight_fetch_if #(.ADDR_W(10), .DATA_W(8)) bus0 ();
  dense_weight_fetch_if #(.ADDR_W(1),  .DATA_W(8)) bus1 ();

  dense_weight_fetch #(.NUM_WEIGHTS(N), .ADDR_W(10), .DATA_W(8), .OFFSET(-1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus0)
  );

  dense_weight_fetch #(.NUM_WEIGHTS(1), .ADDR_W(1), .DATA_W(8), .OFFSET(-1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
  );

  // ROM models: data = addr[7:0] for the big instance, A5 at address 0 for the small one.
  always @(posedge clk) if (bus0.mem_en) bus0.mem_rdata <= bus0.mem_addr[7:0];
  always @(posedge clk) if (bus1.mem_en) bus1.mem_rdata <= 8'hA5;

  // Independent occupancy model of the big instance's buffer.
  int occ_m = 0;
  int infl_m = 0;
  int pop_m;
  bit viol = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ_m  = 0;
      infl_m = 0;
    end else begin
      pop_m = (bus0.w_valid && bus0.w_ready) ? 1 : 0;
      if (bus0.w_valid !== (occ_m != 0)) viol = 1'b1;
      if (bus0.mem_en && (occ_m + infl_m - pop_m) >= 2) viol = 1'b1;
      occ_m  = occ_m + infl_m - pop_m;
      if (occ_m > 2) viol = 1'b1;
      infl_m = bus0.mem_en ? 1 : 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_w(input int i);
    logic [7:0] v;
    v = 8'(i);
    return v + Off8;
  endfunction

  // Streams beats from the big instance, checking order, last flag and stall stability.
  task automatic collect(input int pct, input int stop_at, input bit poke_busy,
                         input bit poke_done, output int nb, output int nd);
    int idx = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [7:0] hold_d;
    logic hold_l;
    nb = 0;
    nd = 0;
    while (cyc < 20000) begin
      @(posedge clk); #1;
      start = 1'b0;
      bus0.w_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      cyc++;
      if (stall) begin
        check("stall_data", bus0.w_data, hold_d);
        check("stall_last", bus0.w_last, hold_l);
      end
      stall  = bus0.w_valid && !bus0.w_ready;
      hold_d = bus0.w_data;
      hold_l = bus0.w_last;
      if (pct == 100 && idx > 0 && idx < N) check("no_gap", bus0.w_valid, 1);
      if (bus0.w_valid && bus0.w_ready) begin
        check("beat_data", bus0.w_data, exp_w(idx));
        check("beat_last", bus0.w_last, (idx == N - 1));
        idx++;
        nb++;
        if (idx == stop_at) return;
      end
      if (poke_busy && idx == 50 && busy) start = 1'b1;
      if (done) begin
        nd++;
        check("busy_in_done", busy, 0);
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus0.w_ready = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        return;
      end
    end
    check("stream_timeout", cyc, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    bus0.w_ready = 1'b0;
    bus1.w_ready = 1'b0;
    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", bus0.mem_en, 0);
    check("rst_mem_addr", bus0.mem_addr, 0);
    check("rst_w_valid", bus0.w_valid, 0);
    check("rst_w_data", bus0.w_data, 0);
    check("rst_w_last", bus0.w_last, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full run, first beat held back to check latency and issue throttling.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_mem_en", bus0.mem_en, 1);
    check("t1_addr0", bus0.mem_addr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_valid", bus0.w_valid, 0);
    check("t2_mem_en", bus0.mem_en, 1);
    check("t2_addr1", bus0.mem_addr, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_valid", bus0.w_valid, 1);
    check("t3_data", bus0.w_data, exp_w(0));
    check("t3_throttle", bus0.mem_en, 0);
    collect(100, 0, 1'b0, 1'b0, beats, dones);
    check("run1_beats", beats, N);
    check("run1_dones", dones, 1);
    check("run1_addr_hold", bus0.mem_addr, N - 1);
    check("run1_buffer", viol, 0);

    // Backpressure at 30% ready.
    @(posedge clk); #1 start = 1'b1;
    collect(30, 0, 1'b0, 1'b0, beats, dones);
    check("run2_beats", beats, N);
    check("run2_dones", dones, 1);
    check("run2_buffer", viol, 0);

    // Single-weight instance with ready held low.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    check("n1_busy", busy1, 1);
    check("n1_mem_en", bus1.mem_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("n1_flush_no_issue", bus1.mem_en, 0);
    check("n1_not_yet_valid", bus1.w_valid, 0);
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("n1_valid", bus1.w_valid, 1);
    check("n1_data", bus1.w_data, 8'hA5 + Off8);
    check("n1_last", bus1.w_last, 1);
    check("n1_no_done_stalled", done1, 0);
    @(posedge clk); #1 bus1.w_ready = 1'b1;
    @(negedge clk);
    check("n1_accept", bus1.w_valid, 1);
    @(posedge clk); #1 bus1.w_ready = 1'b0;
    @(negedge clk);
    check("n1_done", done1, 1);
    check("n1_idle", busy1, 0);
    check("n1_empty", bus1.w_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("n1_done_pulse", done1, 0);

    // Reset mid-run after 100 beats, then a clean restart.
    @(posedge clk); #1 start = 1'b1;
    collect(100, 100, 1'b0, 1'b0, beats, dones);
    check("part_beats", beats, 100);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_en", bus0.mem_en, 0);
    check("mid_rst_addr", bus0.mem_addr, 0);
    check("mid_rst_valid", bus0.w_valid, 0);
    check("mid_rst_data", bus0.w_data, 0);
    check("mid_rst_last", bus0.w_last, 0);
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus0.w_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("restart_addr", bus0.mem_addr, 0);
    check("restart_mem_en", bus0.mem_en, 1);
    collect(100, 0, 1'b0, 1'b0, beats, dones);
    check("run3_beats", beats, N);
    check("run3_dones", dones, 1);

    // Starts during busy and alongside done are dropped; one cycle later one is taken.
    @(posedge clk); #1 start = 1'b1;
    collect(70, 0, 1'b1, 1'b1, beats, dones);
    check("run4_beats", beats, N);
    check("run4_dones", dones, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("late_start_busy", busy, 1);
    check("late_start_addr", bus0.mem_addr, 0);
    collect(100, 0, 1'b0, 1'b0, beats, dones);
    check("run5_beats", beats, N);
    check("run5_buffer", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
